mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Sequencer and arbiter for the single-port 8x32 data memory block (Memory_Access).
- Shares the memory between two requesters: r0 (load/store path) and r1 (debug/DMA path).
- For each granted request: computes the effective address op1+op2, drives one write or read cycle, and returns read data to the owner over a valid pulse.
- Sits between pipeline memory stage and the memory array.

Parameters:
- DW, 32, data width.
- AW, 3, memory address width (2^AW words).
- RD_LAT, 1, cycles from issue edge to mem_rd_data sampled; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- r0_req  input  1  request from requester 0; held until r0_gnt.
- r0_we  input  1  1=write, 0=read.
- r0_op1  input  DW  address operand 1.
- r0_op2  input  DW  address operand 2.
- r0_wdata  input  DW  write data.
- r0_gnt  output  1  one-cycle grant pulse.
- r0_rvalid  output  1  one-cycle read-data-valid pulse.
- r0_rdata  output  DW  read data.
- r1_req, r1_we, r1_op1, r1_op2, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0_*.
- mem_wr_en  output  1  memory write enable.
- mem_rd_en  output  1  memory read enable.
- mem_add  output  AW  memory address.
- mem_data  output  DW  memory write data.
- mem_rd_data  input  DW  memory read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - All gnt, rvalid, mem_wr_en, mem_rd_en and busy = 0.
  - mem_add=0, mem_data=0, r*_rdata=0.
  - Last-grant pointer lp=1, so r0 wins the first tie.
- Reset mid-operation aborts immediately:
  - No rvalid is issued.
  - A write whose ISSUE cycle was already in progress may have been committed by memory; this is acceptable.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Samples r0_req/r1_req at each edge.
  - Single request: that requester wins.
  - Both requesting: the requester != lp wins.
  - On a win: capture we, wdata, and addr=(op1+op2)[AW-1:0]; set owner and lp=winner; next state ISSUE.
  - No request: stay in IDLE.
- Address arithmetic: 32-bit add with carry and upper bits discarded; wrap-around is intentional (e.g. op1=6, op2=3 -> addr 1).
- ISSUE (exactly 1 cycle):
  - owner's gnt=1.
  - mem_add=addr.
  - Write: mem_wr_en=1, mem_data=wdata; next state IDLE. Write occupancy is 2 cycles.
  - Read: mem_rd_en=1; next state RESP if RD_LAT=1, else WAIT with counter=RD_LAT-1.
- WAIT:
  - mem_rd_en=0; mem_add holds addr.
  - Counter decrements each cycle; goes to RESP when it reaches 1.
- RESP:
  - owner's rvalid=1; owner's rdata = mem_rd_data sampled at the edge RD_LAT cycles after ISSUE entry.
  - Next state IDLE.
- Read turnaround from the IDLE sample edge: gnt in cycle +1, rvalid in cycle +1+RD_LAT.
- Non-owner outputs stay 0 throughout. r*_rdata holds its last value between reads.
- Outside ISSUE/WAIT, mem_add and mem_data are 0; mem enables are never both high.
- Requests arriving while busy are not lost; they are serviced when the FSM returns to IDLE.
- Requester obligations:
  - Keep req, we, op1, op2 and wdata stable until gnt.
  - Drop req in the cycle after gnt unless issuing a new request.
- Fairness: with both requesters continuously requesting, grants strictly alternate r0, r1, r0, ...
- A req asserted during RESP is sampled in the following IDLE cycle; there is no bypass from RESP.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - requester-ID constants REQ0=0, REQ1=1;
  - default DW/AW values.
- One sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], lp.
  - Outputs: one-hot win[1:0] and win_id.
  - Combinational; lp is owned by the parent.

Test Plan:
1. Reset mid-read: r0 read in progress, pulse rst_n=0 during WAIT (RD_LAT=3) -> no rvalid, state IDLE, busy=0, all outputs 0 next cycle.
2. Writes then reads: r0 writes data=i to (op1=4, op2=i-4) for i=4..7, then reads back i=7..4 -> mem_add=i on each ISSUE, r0_rdata=7,6,5,4, each rvalid 1 cycle at IDLE-edge+2 (RD_LAT=1).
3. Contention: r0_req and r1_req both held high from reset for 4 transactions -> grant order r0, r1, r0, r1; exactly one gnt per transaction; no overlapping mem enables.
4. Address wrap: op1=32'hFFFF_FFFF, op2=2 read -> mem_add=1; op1=6, op2=3 -> mem_add=1.
5. Latency sweep: RD_LAT=1, 2, 4; memory model returns 32'hA5A5_0000+addr -> rvalid exactly RD_LAT cycles after ISSUE cycle, with correct data.
6. Back-to-back writes: r1 write, then r0 read of the same address -> r0_rdata equals r1's wdata; busy low for exactly the IDLE sample cycles between transactions.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the data-memory access arbiter.
// Holds the FSM state encoding, requester IDs and default widths.
package mem_arb_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 3;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t RESP  = 2'd3;

endpackage

// File: rtl/mem_access_arbiter_rr_arb2.sv
// Two-way round-robin pick. On a tie the requester that did not win last
// time (not lp) takes the grant; the parent owns and updates lp.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lp,
  output logic [1:0] win,
  output logic       win_id
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    win    = 2'b00;
    win_id = REQ0;
    if (req == 2'b11) begin
      win_id = ~lp;
    end else if (req[1]) begin
      win_id = REQ1;
    end
    if (req != 2'b00) begin
      win = 2'b01 << win_id;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-port data memory between two requesters: picks a winner,
// issues one write or read at op1+op2 and returns read data to the owner.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [DW-1:0] r0_op1,
  input  logic [DW-1:0] r0_op2,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [DW-1:0] r1_op1,
  input  logic [DW-1:0] r1_op2,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_rd_data,
  output logic          busy
);

  state_t        state;
  logic          lp;
  logic          owner;
  logic          we_q;
  logic [2:0]    cnt;

  logic [1:0]    win;
  logic          win_id;
  logic [DW-1:0] sum0;
  logic [DW-1:0] sum1;
  logic          sel_we;
  logic [DW-1:0] sel_wdata;
  logic [AW-1:0] sel_addr;
  logic          rd_done;
  logic          unused_sum_hi;

  rr_arb2 u_rr_arb2 (
    .req    ({r1_req, r0_req}),
    .lp     (lp),
    .win    (win),
    .win_id (win_id)
  );

  // Full-width add; only the low AW bits address the memory, so wrap is free.
  assign sum0          = r0_op1 + r0_op2;
  assign sum1          = r1_op1 + r1_op2;
  assign unused_sum_hi = ^{sum0[DW-1:AW], sum1[DW-1:AW]};

  assign sel_we    = (win_id == REQ1) ? r1_we    : r0_we;
  assign sel_wdata = (win_id == REQ1) ? r1_wdata : r0_wdata;
  assign sel_addr  = (win_id == REQ1) ? sum1[AW-1:0] : sum0[AW-1:0];

  // The edge that samples mem_rd_data lands RD_LAT cycles after ISSUE entry.
  assign rd_done = ((state == ISSUE) && !we_q && (RD_LAT == 1)) ||
                   ((state == WAIT) && (cnt == 3'd1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours.
    if (!rst_n) begin
      state     <= IDLE;
      lp        <= REQ1;
      owner     <= REQ0;
      we_q      <= 1'b0;
      cnt       <= 3'd0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_add   <= '0;
      mem_data  <= '0;
      busy      <= 1'b0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;

      if (rd_done) begin
        state   <= RESP;
        mem_add <= '0;
        if (owner == REQ0) begin
          r0_rvalid <= 1'b1;
          r0_rdata  <= mem_rd_data;
        end else begin
          r1_rvalid <= 1'b1;
          r1_rdata  <= mem_rd_data;
        end
      end else begin
        case (state)
          IDLE: begin
            if (win != 2'b00) begin
              state   <= ISSUE;
              busy    <= 1'b1;
              owner   <= win_id;
              lp      <= win_id;
              we_q    <= sel_we;
              r0_gnt  <= win[0];
              r1_gnt  <= win[1];
              mem_add <= sel_addr;
              if (sel_we) begin
                mem_wr_en <= 1'b1;
                mem_data  <= sel_wdata;
              end else begin
                mem_rd_en <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (we_q) begin
              state    <= IDLE;
              busy     <= 1'b0;
              mem_add  <= '0;
              mem_data <= '0;
            end else begin
              state <= WAIT;
              cnt   <= 3'(RD_LAT - 1);
            end
          end
          WAIT: cnt <= cnt - 3'd1;
          RESP: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: four instances (RD_LAT 1..4) each with a
// behavioural memory, driven by directed and random transactions.
module tb_mem_access_arbiter;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req    [NI][2];
  logic        we     [NI][2];
  logic [31:0] op1    [NI][2];
  logic [31:0] op2    [NI][2];
  logic [31:0] wdata  [NI][2];
  logic        gnt    [NI][2];
  logic        rvalid [NI][2];
  logic [31:0] rdata  [NI][2];
  logic        mem_wr_en   [NI];
  logic        mem_rd_en   [NI];
  logic        busy        [NI];
  logic [2:0]  mem_add     [NI];
  logic [31:0] mem_data    [NI];
  logic [31:0] mem_rd_data [NI];
  logic        mem_init = 1'b0;

  logic [31:0] model [NI][8];
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] arr [8];

    mem_access_arbiter #(.DW(32), .AW(3), .RD_LAT(g + 1)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .r0_req      (req[g][0]),
      .r0_we       (we[g][0]),
      .r0_op1      (op1[g][0]),
      .r0_op2      (op2[g][0]),
      .r0_wdata    (wdata[g][0]),
      .r0_gnt      (gnt[g][0]),
      .r0_rvalid   (rvalid[g][0]),
      .r0_rdata    (rdata[g][0]),
      .r1_req      (req[g][1]),
      .r1_we       (we[g][1]),
      .r1_op1      (op1[g][1]),
      .r1_op2      (op2[g][1]),
      .r1_wdata    (wdata[g][1]),
      .r1_gnt      (gnt[g][1]),
      .r1_rvalid   (rvalid[g][1]),
      .r1_rdata    (rdata[g][1]),
      .mem_wr_en   (mem_wr_en[g]),
      .mem_rd_en   (mem_rd_en[g]),
      .mem_add     (mem_add[g]),
      .mem_data    (mem_data[g]),
      .mem_rd_data (mem_rd_data[g]),
      .busy        (busy[g])
    );

    assign mem_rd_data[g] = arr[mem_add[g]];

    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 8; i++) arr[i] <= 32'hA5A5_0000 + 32'(i);
      end else if (mem_wr_en[g]) begin
        arr[mem_add[g]] <= mem_data[g];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NI; c++) begin
        check("en_excl", 32'(mem_wr_en[c] & mem_rd_en[c]), 32'd0);
        check("gnt_excl", 32'(gnt[c][0] & gnt[c][1]), 32'd0);
      end
    end
  end

  // One complete transaction from an idle arbiter, checked against the
  // word-level model: grant next cycle, rvalid RD_LAT cycles after grant.
  task automatic do_txn(input int c, input int id, input logic w_e,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] wd);
    logic [31:0] s;
    int ea, n, k;
    s  = a + b;
    ea = int'(s % 32'd8);
    req[c][id]   = 1'b1;
    we[c][id]    = w_e;
    op1[c][id]   = a;
    op2[c][id]   = b;
    wdata[c][id] = wd;
    n = 0;
    do begin step(); n++; end while (!gnt[c][id] && n < 20);
    req[c][id] = 1'b0;
    check("gnt_seen", 32'(gnt[c][id]), 32'd1);
    check("gnt_lat", n, 1);
    check("gnt_other", 32'(gnt[c][1-id]), 32'd0);
    check("busy_issue", 32'(busy[c]), 32'd1);
    check("mem_add", 32'(mem_add[c]), ea);
    check("wr_en", 32'(mem_wr_en[c]), 32'(w_e));
    check("rd_en", 32'(mem_rd_en[c]), 32'(!w_e));
    check("mem_data", mem_data[c], w_e ? wd : 32'd0);
    if (w_e) begin
      model[c][ea] = wd;
      step();
      check("busy_wr_done", 32'(busy[c]), 32'd0);
      check("mem_add_idle", 32'(mem_add[c]), 32'd0);
      check("mem_data_idle", mem_data[c], 32'd0);
    end else begin
      k = 0;
      do begin step(); k++; end while (!rvalid[c][id] && k < 10);
      check("rd_lat", k, c + 1);
      check("rdata", rdata[c][id], model[c][ea]);
      check("rvalid_other", 32'(rvalid[c][1-id]), 32'd0);
      check("mem_add_resp", 32'(mem_add[c]), 32'd0);
      step();
      check("rvalid_pulse", 32'(rvalid[c][id]), 32'd0);
      check("busy_rd_done", 32'(busy[c]), 32'd0);
      check("rdata_hold", rdata[c][id], model[c][ea]);
    end
  endtask

  initial begin
    int n, cycles;
    int order[$];
    logic [31:0] w;

    for (int c = 0; c < NI; c++) begin
      for (int r = 0; r < 2; r++) begin
        req[c][r] = 1'b0; we[c][r] = 1'b0;
        op1[c][r] = '0; op2[c][r] = '0; wdata[c][r] = '0;
      end
      for (int i = 0; i < 8; i++) model[c][i] = 32'hA5A5_0000 + 32'(i);
    end

    // Reset state on every instance
    mem_init = 1'b1;
    step(); step();
    mem_init = 1'b0;
    for (int c = 0; c < NI; c++) begin
      check("rst_busy", 32'(busy[c]), 32'd0);
      check("rst_gnt", 32'(gnt[c][0] | gnt[c][1]), 32'd0);
      check("rst_rvalid", 32'(rvalid[c][0] | rvalid[c][1]), 32'd0);
      check("rst_en", 32'(mem_wr_en[c] | mem_rd_en[c]), 32'd0);
      check("rst_add", 32'(mem_add[c]), 32'd0);
      check("rst_data", mem_data[c], 32'd0);
      check("rst_rdata0", rdata[c][0], 32'd0);
      check("rst_rdata1", rdata[c][1], 32'd0);
    end
    mon_en = 1'b1;
    rst_n  = 1'b1;
    step();

    // Reset during WAIT on the RD_LAT=3 instance aborts the read
    req[2][0] = 1'b1; we[2][0] = 1'b0; op1[2][0] = 32'd1; op2[2][0] = 32'd2;
    n = 0;
    do begin step(); n++; end while (!gnt[2][0] && n < 20);
    req[2][0] = 1'b0;
    check("abort_gnt", 32'(gnt[2][0]), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", 32'(busy[2]), 32'd0);
    check("abort_rvalid", 32'(rvalid[2][0]), 32'd0);
    check("abort_en", 32'(mem_wr_en[2] | mem_rd_en[2]), 32'd0);
    check("abort_add", 32'(mem_add[2]), 32'd0);
    check("abort_rdata", rdata[2][0], 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_rvalid", 32'(rvalid[2][0]), 32'd0);
      check("abort_idle", 32'(busy[2]), 32'd0);
    end

    // Contention: both requesters write continuously, grants alternate from r0
    req[2][0] = 1'b1; we[2][0] = 1'b1; op1[2][0] = 32'd2; op2[2][0] = 32'd0; wdata[2][0] = 32'h100;
    req[2][1] = 1'b1; we[2][1] = 1'b1; op1[2][1] = 32'd1; op2[2][1] = 32'd2; wdata[2][1] = 32'h200;
    cycles = 0;
    while (order.size() < 4 && cycles < 40) begin
      step();
      cycles++;
      if (gnt[2][0]) order.push_back(0);
      if (gnt[2][1]) order.push_back(1);
    end
    req[2][0] = 1'b0;
    req[2][1] = 1'b0;
    check("cont_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check("cont_order", order[i], i % 2);
    model[2][2] = 32'h100;
    model[2][3] = 32'h200;
    step(); step();
    do_txn(2, 1, 1'b0, 32'd3, 32'd0, 32'd0);
    do_txn(2, 0, 1'b0, 32'd2, 32'd0, 32'd0);

    // Writes of i to address i, then reads back in reverse (RD_LAT=1)
    for (int i = 4; i <= 7; i++) do_txn(0, 0, 1'b1, 32'd4, 32'(i - 4), 32'(i));
    for (int i = 7; i >= 4; i--) begin
      do_txn(0, 0, 1'b0, 32'd4, 32'(i - 4), 32'd0);
      check("wr_rd_value", rdata[0][0], 32'(i));
    end

    // Address wrap-around
    do_txn(0, 0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0);
    check("wrap_a", rdata[0][0], model[0][1]);
    do_txn(0, 1, 1'b0, 32'd6, 32'd3, 32'd0);
    check("wrap_b", rdata[0][1], model[0][1]);

    // Back-to-back: r1 write then r0 read of the same word (RD_LAT=2)
    w = $urandom;
    do_txn(1, 1, 1'b1, 32'd2, 32'd3, w);
    do_txn(1, 0, 1'b0, 32'd5, 32'd0, 32'd0);
    check("b2b_data", rdata[1][0], w);

    // Random traffic on RD_LAT = 1, 2 and 4
    for (int c = 0; c < NI; c++) begin
      if (c != 2) begin
        for (int t = 0; t < 15; t++) begin
          do_txn(c, int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 $urandom, $urandom, $urandom);
        end
      end
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
